alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Multi-cycle execution unit directly downstream of the ALU decoder; consumes its 4-bit ALUControl plus SrcA/SrcB and produces ALUResult/Zero.
- Logic/arithmetic/compare ops complete in one cycle. Shifts use an iterative 1-bit-per-cycle shifter, trading latency for area.
- A start/busy/done handshake lets the control FSM stall the pipeline while a shift is in flight.

Parameters:
- WIDTH, 32, datapath width in bits.
- SHW, 5, shift-amount width, equal to log2(WIDTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- ALUControl  input  4  operation code from the ALU decoder.
- SrcA  input  WIDTH  operand A.
- SrcB  input  WIDTH  operand B; SrcB[SHW-1:0] is the shift amount.
- ALUResult  output  WIDTH  result, held stable from done until the next accepted start.
- Zero  output  1  high when ALUResult==0; registered together with ALUResult.
- busy  output  1  high while an operation is in flight (SHIFT state).
- done  output  1  one-cycle pulse; result valid this cycle.
- illegal  output  1  high alongside done when the accepted ALUControl was unencoded.

Behaviour:
- Opcodes: 0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt (signed), 0110 sltu, 0111 sll, 1000 srl, 1001 sra. Codes 1010-1111 are illegal.
- Arithmetic: add/sub wrap modulo 2^WIDTH; no carry/overflow output. slt/sltu return {WIDTH-1 zeros, bit}.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE/DONE + start=1, non-shift op or shamt==0: compute, register result → DONE.
  - IDLE/DONE + start=1, shift op with shamt!=0: latch SrcA into shift register, cnt=shamt, latch op → SHIFT.
  - IDLE/DONE + start=0: DONE → IDLE; IDLE stays.
  - SHIFT: each cycle shift 1 bit (sll: <<1 zero-fill; srl: >>1 zero-fill; sra: >>1 sign-fill), cnt-=1. When cnt==1 at the edge → DONE with the final value written to ALUResult.
- done=1 exactly in DONE state. busy=1 exactly in SHIFT state. illegal is valid only with done.
- Latency, start sampled at edge T:
  - non-shift, or shamt==0: done in cycle T+1.
  - shift by n: busy during T+1..T+n, done in T+n+1.
- Back-to-back: start in the DONE cycle is accepted; done then deasserts or re-pulses per the new op. Single-cycle ops can therefore stream with done held high on consecutive cycles.
- start while busy=1 is ignored: no queuing, operands not re-latched, in-flight op unaffected.
- Operand inputs may change after acceptance without affecting the result.
- Illegal op: ALUResult=0, Zero=1, illegal=1, single-cycle latency.
- ALUResult/Zero update only on entry to DONE; they hold their value through IDLE and SHIFT.
- Reset: FSM→IDLE, ALUResult=0, Zero=1, busy=0, done=0, illegal=0, cnt=0.
- Reset asserted mid-SHIFT aborts the op with no done pulse. The first start after reset deasserts is accepted normally.
- Reset and start in the same cycle: reset wins, start is dropped.

Test Plan:
- reset, then start add SrcA=5 SrcB=7 → done at T+1, ALUResult=12, Zero=0; sub 3-3 → 0, Zero=1; add 0xFFFFFFFF+1 → 0, Zero=1.
- slt SrcA=0xFFFFFFFF SrcB=1 → 1; sltu same operands → 0; xor 0xF0F0F0F0^0xFFFF0000 → 0x0F0FF0F0.
- sra SrcA=0x80000000 SrcB=4 → busy for 4 cycles, done at T+5, 0xF8000000; srl same → 0x08000000; sll 1 by 31 → 0x80000000, done at T+32; sll by 0 → done at T+1, result=SrcA.
- During an sll by 10, pulse start with an add and change SrcA → ignored, shift result correct; start in the DONE cycle with and 0xFF&0x0F → accepted, done at next cycle = 0x0F.
- Assert reset in the 3rd SHIFT cycle of srl by 8 → no done, ALUResult=0, busy=0 next cycle; subsequent add 1+1 → 2.
- ALUControl=1011 → done at T+1, illegal=1, ALUResult=0, Zero=1; the next legal op deasserts illegal.

Source files
------------

// File: rtl/alu_iter.sv
// alu_iter: multi-cycle ALU. Single-cycle logic/arith/compare, iterative 1-bit/cycle shifter.
module alu_iter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       ALUControl,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   output logic [WIDTH-1:0] ALUResult,
   output logic             Zero,
   output logic             busy,
   output logic             done,
   output logic             illegal
);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;

   logic [WIDTH-1:0] alu_res;
   logic             op_illegal;
   logic             op_shift;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] shift_one;

   // Single-cycle result; shift ops yield SrcA since only shamt==0 finishes here.
   always_comb begin
      alu_res    = '0;
      op_illegal = 1'b0;
      op_shift   = 1'b0;
      shamt      = SrcB[SHW-1:0];
      case (ALUControl)
         OP_ADD:  alu_res = SrcA + SrcB;
         OP_SUB:  alu_res = SrcA - SrcB;
         OP_AND:  alu_res = SrcA & SrcB;
         OP_OR:   alu_res = SrcA | SrcB;
         OP_XOR:  alu_res = SrcA ^ SrcB;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
         OP_SLL, OP_SRL, OP_SRA: begin
            alu_res  = SrcA;
            op_shift = 1'b1;
         end
         default: op_illegal = 1'b1;
      endcase
   end

   // One-bit step of the latched shift operation.
   always_comb begin
      case (op_q)
         OP_SLL:  shift_one = {shreg_q[WIDTH-2:0], 1'b0};
         OP_SRL:  shift_one = {1'b0, shreg_q[WIDTH-1:1]};
         default: shift_one = {shreg_q[WIDTH-1], shreg_q[WIDTH-1:1]};
      endcase
   end

   // Next-state and datapath update; result/Zero change only on entry to DONE.
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = 1'b0;
      shreg_d   = shreg_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               if (op_shift && (shamt != '0)) begin
                  shreg_d = SrcA;
                  cnt_d   = shamt;
                  op_d    = ALUControl;
                  state_d = S_SHIFT;
               end else begin
                  result_d  = alu_res;
                  zero_d    = (alu_res == '0);
                  illegal_d = op_illegal;
                  state_d   = S_DONE;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SHIFT: begin
            shreg_d = shift_one;
            cnt_d   = cnt_q - SHW'(1);
            if (cnt_q == SHW'(1)) begin
               result_d = shift_one;
               zero_d   = (shift_one == '0);
               state_d  = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d == S_SHIFT);
      done_d = (state_d == S_DONE);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         result_q  <= '0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         shreg_q   <= '0;
         cnt_q     <= '0;
         op_q      <= '0;
      end else begin
         state_q   <= state_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         shreg_q   <= shreg_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
      end
   end

   assign ALUResult = result_q;
   assign Zero      = zero_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed cases plus random stimulus against a cycle model.
module tb_alu_iter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [3:0]  ALUControl = 4'd0;
   logic [31:0] SrcA = '0;
   logic [31:0] SrcB = '0;
   logic [31:0] ALUResult;
   logic        Zero, busy, done, illegal;

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   alu_iter #(.WIDTH(32), .SHW(5)) dut (
      .clk(clk), .reset(reset), .start(start), .ALUControl(ALUControl),
      .SrcA(SrcA), .SrcB(SrcB), .ALUResult(ALUResult), .Zero(Zero),
      .busy(busy), .done(done), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: full result from plain arithmetic; illegal flagged separately.
   function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, output bit ill);
      int n;
      n   = int'(b[4:0]);
      ill = 1'b0;
      case (op)
         4'd0: return a + b;
         4'd1: return a - b;
         4'd2: return a & b;
         4'd3: return a | b;
         4'd4: return a ^ b;
         4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd6: return (a < b) ? 32'd1 : 32'd0;
         4'd7: return a << n;
         4'd8: return a >> n;
         4'd9: return 32'($signed(a) >>> n);
         default: begin ill = 1'b1; return 32'd0; end
      endcase
   endfunction

   // Model: count of remaining busy cycles plus the pending/visible result.
   int          m_left = 0;
   logic [31:0] m_pend = '0;
   logic [31:0] m_res  = '0;
   bit          m_done = 1'b0;
   bit          m_ill  = 1'b0;

   always @(posedge clk) begin
      logic [31:0] r;
      bit          il;
      if (reset) begin
         m_left = 0; m_res = '0; m_done = 1'b0; m_ill = 1'b0;
      end else if (m_left > 0) begin
         m_left--;
         m_done = (m_left == 0);
         m_ill  = 1'b0;
         if (m_left == 0) m_res = m_pend;
      end else if (start) begin
         r = ref_op(ALUControl, SrcA, SrcB, il);
         if ((ALUControl inside {4'd7, 4'd8, 4'd9}) && (SrcB[4:0] != 5'd0)) begin
            m_left = int'(SrcB[4:0]);
            m_pend = r;
            m_done = 1'b0;
            m_ill  = 1'b0;
         end else begin
            m_res  = r;
            m_done = 1'b1;
            m_ill  = il;
         end
      end else begin
         m_done = 1'b0;
         m_ill  = 1'b0;
      end
   end

   // Compare DUT against model every cycle, away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("model_result", ALUResult, m_res);
         chk("model_zero", 32'(Zero), 32'(m_res == 32'd0));
         chk("model_busy", 32'(busy), 32'(m_left > 0));
         chk("model_done", 32'(done), 32'(m_done));
         if (m_done) chk("model_illegal", 32'(illegal), 32'(m_ill));
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op, then wait for done; returns latency in cycles after the start edge.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      start = 1'b1; ALUControl = op; SrcA = a; SrcB = b;
      step();
      start = 1'b0; SrcA = $urandom; SrcB = $urandom; ALUControl = 4'($urandom);
      lat = 1;
      while (!done && lat < 64) begin
         step();
         lat++;
      end
   endtask

   task automatic directed(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      run_op(op, a, b, lat);
      chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({name, "_res"}, ALUResult, exp_res);
      chk({name, "_zero"}, 32'(Zero), 32'(exp_res == 32'd0));
   endtask

   initial begin
      int lat;
      repeat (2) step();
      cmp_en = 1'b1;
      chk("rst_result", ALUResult, 32'd0);
      chk("rst_zero", 32'(Zero), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      reset = 1'b0;
      step();

      directed("add", 4'd0, 32'd5, 32'd7, 32'd12, 1);
      directed("sub", 4'd1, 32'd3, 32'd3, 32'd0, 1);
      directed("add_wrap", 4'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
      directed("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
      directed("sltu", 4'd6, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
      directed("xor", 4'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 1);
      directed("sra4", 4'd9, 32'h8000_0000, 32'd4, 32'hF800_0000, 5);
      directed("srl4", 4'd8, 32'h8000_0000, 32'd4, 32'h0800_0000, 5);
      directed("sll31", 4'd7, 32'd1, 32'd31, 32'h8000_0000, 32);
      directed("sll0", 4'd7, 32'hDEAD_BEEF, 32'd0, 32'hDEAD_BEEF, 1);

      // start while busy is ignored, operands changed mid-flight
      start = 1'b1; ALUControl = 4'd7; SrcA = 32'h1234_5678; SrcB = 32'd10;
      step();
      start = 1'b1; ALUControl = 4'd0; SrcA = 32'h0000_0001; SrcB = 32'd1;
      step();
      start = 1'b0;
      lat = 2;
      while (!done && lat < 64) begin step(); lat++; end
      chk("ign_lat", 32'(lat), 32'd11);
      chk("ign_res", ALUResult, 32'hD159_E000);
      // back-to-back start in the DONE cycle
      directed("b2b_and", 4'd2, 32'h0000_00FF, 32'h0000_000F, 32'h0000_000F, 1);

      // reset in the third SHIFT cycle of srl by 8
      start = 1'b1; ALUControl = 4'd8; SrcA = 32'h8000_0000; SrcB = 32'd8;
      step();
      start = 1'b0;
      step(); step();
      chk("abort_busy_before", 32'(busy), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_result", ALUResult, 32'd0);
      step();
      chk("abort_no_late_done", 32'(done), 32'd0);
      directed("post_rst_add", 4'd0, 32'd1, 32'd1, 32'd2, 1);

      // illegal opcode, then legal op clears illegal
      directed("ill", 4'b1011, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1);
      chk("ill_flag", 32'(illegal), 32'd1);
      directed("after_ill", 4'd3, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1);
      chk("after_ill_flag", 32'(illegal), 32'd0);

      // random traffic: start toggling freely, occasional reset
      for (int i = 0; i < 1500; i++) begin
         start      = ($urandom_range(0, 2) != 0);
         ALUControl = 4'($urandom_range(0, 15));
         SrcA       = $urandom;
         SrcB       = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
         reset      = ($urandom_range(0, 99) == 0);
         step();
      end
      reset = 1'b0;
      start = 1'b0;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
